// File: rtl/ysyx_23060203_axi_reader_if.sv
// AXI4 bus bundle between the read initiator and the crossbar.
// The read channels are the live path. The write-channel handshake
// signals are included so the initiator can hold them inactive.
interface axi_if #(
  parameter int ADDR_W = 32
) ();

  // Read address channel
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  // Read data channel
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  // Write-channel handshakes, held idle by a read-only initiator
  logic              awvalid;
  logic              wvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst, rready,
    output awvalid, wvalid, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
    input  awvalid, wvalid, bready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/ysyx_23060203_axi_reader.sv
// AXI4 read initiator.
// It turns a client valid/ready read request into one INCR AR transaction.
// Each R beat passes through a 2-entry response FIFO.
// Only one transaction is outstanding at a time.
// Slave errors, rid mismatches and rlast mismatches are reported through a
// sticky error flag.
module ysyx_23060203_axi_reader #(
  parameter int ID     = 0,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,

  // Client request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [7:0]        req_len,

  // Client response side (FIFO head)
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_last,
  output logic              resp_err,

  // Status
  output logic              err_sticky,
  input  logic              err_clear,
  output logic              busy,

  // AXI bus
  axi_if.master             read
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } entry_t;

  localparam logic [3:0] ID_VAL = 4'(ID);

  state_t            state;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [7:0]        cnt;

  entry_t            fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              r_ready;
  logic              beat_acc;
  logic              beat_last;
  logic              fifo_push;
  logic              fifo_pop;
  logic              beat_bad;

  // Handshake outputs depend only on registered state and FIFO occupancy.
  // This keeps every combinational path from the bus or the client out of them.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign r_ready   = (state == DATA) && (fifo_count != 2'd2);

  assign read.arvalid = (state == ADDR);
  assign read.araddr  = araddr_q;
  assign read.arlen   = arlen_q;
  assign read.arsize  = arsize_q;
  assign read.arid    = ID_VAL;
  assign read.arburst = 2'b01;
  assign read.rready  = r_ready;
  assign read.awvalid = 1'b0;
  assign read.wvalid  = 1'b0;
  assign read.bready  = 1'b0;

  // The beat counter, not rlast, decides which beat ends the transaction.
  assign beat_acc  = read.rvalid && r_ready;
  assign beat_last = (cnt == arlen_q);
  assign fifo_push = beat_acc;
  assign fifo_pop  = resp_valid && resp_ready;

  // A protocol or slave error is flagged, but the beat is still delivered.
  assign beat_bad = (read.rresp != 2'b00) ||
                    (read.rid != ID_VAL) ||
                    (read.rlast != beat_last);

  // FSM: the request latches AR fields, then the address phase and data phase follow.
  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from values sampled before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            araddr_q <= req_addr;
            arlen_q  <= req_len;
            arsize_q <= req_size;
            cnt      <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (read.arready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (beat_acc) begin
            cnt <= cnt + 8'd1;
            if (beat_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage: write the entry at the write pointer on each accepted beat.
  // NOTE: the data array has no reset. Occupancy is tracked by fifo_count, so
  // stale contents are never presented as valid.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= '{data: read.rdata,
                            err:  (read.rresp != 2'b00),
                            last: beat_last};
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flag. A new error wins over a clear in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (beat_acc && beat_bad) begin
      err_sticky <= 1'b1;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
    end
  end

  assign resp_valid = (fifo_count != 2'd0);
  assign resp_data  = fifo_mem[rd_ptr].data;
  assign resp_err   = fifo_mem[rd_ptr].err;
  assign resp_last  = fifo_mem[rd_ptr].last;

endmodule

// File: tb/tb_ysyx_23060203_axi_reader.sv
// Directed testbench for ysyx_23060203_axi_reader.
// The bench plays the AXI slave cycle by cycle.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at that same point.
module tb_ysyx_23060203_axi_reader;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  logic        err_sticky;
  logic        err_clear;
  logic        busy;

  int checks;
  int failures;

  axi_if #(.ADDR_W(32)) axi ();

  ysyx_23060203_axi_reader #(.ID(0), .ADDR_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .err_sticky (err_sticky),
    .err_clear  (err_clear),
    .busy       (busy),
    .read       (axi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge. The caller ensures the DUT is in IDLE.
  task automatic issue_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_size  = s;
    step();
    req_valid = 1'b0;
  endtask

  task automatic ar_handshake();
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
  endtask

  // Present one R beat for one edge. The beat stays driven until the caller changes it.
  task automatic beat(input logic [31:0] d, input logic [1:0] rr, input logic lst);
    axi.rvalid = 1'b1;
    axi.rdata  = d;
    axi.rresp  = rr;
    axi.rlast  = lst;
    axi.rid    = 4'd0;
    step();
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (axi.arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", axi.arvalid); end
    checks++; if (axi.rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", axi.rready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
  endtask

  task automatic test_single();
    resp_ready = 1'b0;
    issue_req(32'h0200_BFF8, 8'd0, 3'd2);
    checks++; if (axi.arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid got=%b exp=1", axi.arvalid); end
    checks++; if (axi.araddr !== 32'h0200_BFF8) begin failures++; $display("FAIL single_araddr got=%h exp=0200bff8", axi.araddr); end
    checks++; if (axi.arlen !== 8'd0 || axi.arsize !== 3'd2 || axi.arburst !== 2'b01 || axi.arid !== 4'd0) begin
      failures++; $display("FAIL single_ar_fields got len=%0d size=%0d burst=%b id=%0d exp 0/2/01/0", axi.arlen, axi.arsize, axi.arburst, axi.arid); end
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_busy got ready=%b busy=%b exp 0/1", req_ready, busy); end
    ar_handshake();
    checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1) begin failures++; $display("FAIL single_after_ar got arvalid=%b rready=%b exp 0/1", axi.arvalid, axi.rready); end
    beat(32'h1234_5678, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678) begin failures++; $display("FAIL single_data got v=%b d=%h exp 1/12345678", resp_valid, resp_data); end
    checks++; if (resp_last !== 1'b1 || resp_err !== 1'b0) begin failures++; $display("FAIL single_flags got last=%b err=%b exp 1/0", resp_last, resp_err); end
    checks++; if (busy !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL single_end got busy=%b sticky=%b exp 0/0", busy, err_sticky); end
    resp_ready = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_burst_backpressure();
    resp_ready = 1'b0;
    issue_req(32'h8000_0000, 8'd3, 3'd2);
    ar_handshake();
    beat(32'hB000_0000, 2'b00, 1'b0);
    checks++; if (axi.rready !== 1'b1) begin failures++; $display("FAIL burst_rready1 got=%b exp=1", axi.rready); end
    beat(32'hB000_0001, 2'b00, 1'b0);
    checks++; if (axi.rready !== 1'b0) begin failures++; $display("FAIL burst_rready_full got=%b exp=0", axi.rready); end
    checks++; if (resp_data !== 32'hB000_0000 || resp_last !== 1'b0) begin failures++; $display("FAIL burst_head0 got d=%h last=%b exp b0000000/0", resp_data, resp_last); end
    beat(32'hB000_0002, 2'b00, 1'b0);
    checks++; if (axi.rready !== 1'b0 || resp_data !== 32'hB000_0000) begin failures++; $display("FAIL burst_stall got rready=%b d=%h exp 0/b0000000", axi.rready, resp_data); end
    resp_ready = 1'b1;
    step();
    checks++; if (resp_data !== 32'hB000_0001 || resp_valid !== 1'b1) begin failures++; $display("FAIL burst_head1 got v=%b d=%h exp 1/b0000001", resp_valid, resp_data); end
    step();
    checks++; if (resp_data !== 32'hB000_0002 || resp_last !== 1'b0) begin failures++; $display("FAIL burst_head2 got d=%h last=%b exp b0000002/0", resp_data, resp_last); end
    beat(32'hB000_0003, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_data !== 32'hB000_0003 || resp_last !== 1'b1) begin failures++; $display("FAIL burst_head3 got d=%h last=%b exp b0000003/1", resp_data, resp_last); end
    checks++; if (busy !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL burst_end got busy=%b sticky=%b exp 0/0", busy, err_sticky); end
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL burst_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_ar_stall();
    resp_ready = 1'b1;
    issue_req(32'h8000_0010, 8'd1, 3'd2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h8000_0010 || axi.arlen !== 8'd1 || axi.rready !== 1'b0) begin
        failures++;
        $display("FAIL ar_stall_cycle%0d got arvalid=%b addr=%h len=%0d rready=%b exp 1/80000010/1/0",
                 i, axi.arvalid, axi.araddr, axi.arlen, axi.rready);
      end
      if (i < 5) step();
    end
    ar_handshake();
    checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1) begin failures++; $display("FAIL ar_stall_after got arvalid=%b rready=%b exp 0/1", axi.arvalid, axi.rready); end
    beat(32'hD000_0000, 2'b00, 1'b0);
    beat(32'hD000_0001, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_data !== 32'hD000_0001 || resp_last !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ar_stall_data got d=%h last=%b busy=%b exp d0000001/1/0", resp_data, resp_last, busy); end
    step();
  endtask

  task automatic test_resp_err();
    resp_ready = 1'b1;
    issue_req(32'h1000_0000, 8'd1, 3'd2);
    ar_handshake();
    beat(32'h0000_00E0, 2'b00, 1'b0);
    checks++; if (resp_err !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL err_beat0 got err=%b sticky=%b exp 0/0", resp_err, err_sticky); end
    beat(32'h0000_00E1, 2'b10, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_data !== 32'h0000_00E1 || resp_err !== 1'b1) begin failures++; $display("FAIL err_beat1 got d=%h err=%b exp 000000e1/1", resp_data, resp_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_sticky_set got=%b exp=1", err_sticky); end
    step();
    checks++; if (err_sticky !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL err_sticky_hold got sticky=%b v=%b exp 1/0", err_sticky, resp_valid); end
    issue_req(32'h1000_0100, 8'd0, 3'd2);
    ar_handshake();
    err_clear = 1'b1;
    beat(32'h0000_00E2, 2'b11, 1'b1);
    err_clear = 1'b0;
    axi.rvalid = 1'b0;
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_set_beats_clear got=%b exp=1", err_sticky); end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_sticky); end
  endtask

  task automatic test_rlast_err();
    resp_ready = 1'b1;
    issue_req(32'h2000_0000, 8'd2, 3'd2);
    ar_handshake();
    beat(32'h0000_00C0, 2'b00, 1'b1);
    checks++; if (err_sticky !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rlast_early got sticky=%b busy=%b exp 1/1", err_sticky, busy); end
    checks++; if (resp_data !== 32'h0000_00C0 || resp_last !== 1'b0) begin failures++; $display("FAIL rlast_beat0 got d=%h last=%b exp 000000c0/0", resp_data, resp_last); end
    beat(32'h0000_00C1, 2'b00, 1'b0);
    checks++; if (resp_data !== 32'h0000_00C1 || busy !== 1'b1) begin failures++; $display("FAIL rlast_beat1 got d=%h busy=%b exp 000000c1/1", resp_data, busy); end
    beat(32'h0000_00C2, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_data !== 32'h0000_00C2 || resp_last !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rlast_beat2 got d=%h last=%b busy=%b exp 000000c2/1/0", resp_data, resp_last, busy); end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if (err_sticky !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rlast_cleanup got sticky=%b v=%b exp 0/0", err_sticky, resp_valid); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b0;
    issue_req(32'h3000_0000, 8'd0, 3'd2);
    ar_handshake();
    beat(32'h1111_1111, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    issue_req(32'h3000_0004, 8'd0, 3'd2);
    checks++; if (busy !== 1'b1 || axi.araddr !== 32'h3000_0004) begin failures++; $display("FAIL b2b_accept got busy=%b addr=%h exp 1/30000004", busy, axi.araddr); end
    ar_handshake();
    beat(32'h2222_2222, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_data !== 32'h1111_1111 || axi.rready !== 1'b0) begin failures++; $display("FAIL b2b_head0 got d=%h rready=%b exp 11111111/0", resp_data, axi.rready); end
    resp_ready = 1'b1;
    step();
    checks++; if (resp_data !== 32'h2222_2222 || resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_head1 got v=%b d=%h exp 1/22222222", resp_valid, resp_data); end
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_len255();
    resp_ready = 1'b1;
    issue_req(32'h4000_0000, 8'd255, 3'd2);
    ar_handshake();
    for (int i = 0; i < 256; i++) begin
      beat(32'(i), 2'b00, (i == 255));
      checks++;
      if (resp_data !== 32'(i) || resp_last !== (i == 255) || busy !== (i != 255)) begin
        failures++;
        $display("FAIL len255_beat%0d got d=%h last=%b busy=%b", i, resp_data, resp_last, busy);
      end
    end
    axi.rvalid = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL len255_end got v=%b sticky=%b exp 0/0", resp_valid, err_sticky); end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    issue_req(32'h5000_0000, 8'd3, 3'd2);
    ar_handshake();
    beat(32'hAA00_0000, 2'b00, 1'b0);
    beat(32'hAA00_0001, 2'b00, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_async got arvalid=%b rready=%b v=%b exp 0/0/0", axi.arvalid, axi.rready, resp_valid); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got ready=%b busy=%b exp 1/0", req_ready, busy); end
    axi.rvalid = 1'b0;
    step();
    @(negedge clock);
    reset = 1'b0;
    step();
    resp_ready = 1'b1;
    issue_req(32'h5000_0100, 8'd0, 3'd2);
    ar_handshake();
    beat(32'hCAFE_F00D, 2'b00, 1'b1);
    axi.rvalid = 1'b0;
    checks++; if (resp_data !== 32'hCAFE_F00D || resp_last !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_fresh got d=%h last=%b busy=%b exp cafef00d/1/0", resp_data, resp_last, busy); end
    step();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_size    = '0;
    req_len     = '0;
    resp_ready  = 1'b0;
    err_clear   = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    axi.rid     = '0;
    #2 reset = 1'b1;
    #1;
    test_reset();
    step();
    step();
    @(negedge clock);
    reset = 1'b0;
    step();
    test_single();
    test_burst_backpressure();
    test_ar_stall();
    test_resp_err();
    test_rlast_err();
    test_back_to_back();
    test_len255();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
